// File: rtl/cachelinebus_if.sv
// Cache-side line request and memory-side beat port of cachelinebus, bundled.
// slave is the responder's view; master is the view of the cache plus memory around it.
interface cachelinebus_if #(
  parameter int PA_BITS = 34,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  parameter int LOGBWPL = 3
);
  // cache side
  logic                FlushStage;
  logic [1:0]          CacheBusRW;
  logic [PA_BITS-1:0]  CacheBusAdr;
  logic [BEATLEN-1:0]  ReadDataWord;
  logic [LINELEN-1:0]  FetchBuffer;
  logic [LOGBWPL-1:0]  BeatCount;
  logic                SelBusBeat;
  logic                CacheBusAck;
  logic                BusCommitted;
  // memory side
  logic                MemReq;
  logic                MemWrite;
  logic [PA_BITS-1:0]  MemAdr;
  logic [BEATLEN-1:0]  MemWData;
  logic                MemLast;
  logic                MemReady;
  logic                MemRValid;
  logic [BEATLEN-1:0]  MemRData;

  modport slave (
    input  FlushStage, CacheBusRW, CacheBusAdr, ReadDataWord,
           MemReady, MemRValid, MemRData,
    output FetchBuffer, BeatCount, SelBusBeat, CacheBusAck, BusCommitted,
           MemReq, MemWrite, MemAdr, MemWData, MemLast
  );

  modport master (
    output FlushStage, CacheBusRW, CacheBusAdr, ReadDataWord,
           MemReady, MemRValid, MemRData,
    input  FetchBuffer, BeatCount, SelBusBeat, CacheBusAck, BusCommitted,
           MemReq, MemWrite, MemAdr, MemWData, MemLast
  );
endinterface

// File: rtl/cachelinebus.sv
// cachelinebus: turns one cache line fetch or writeback into LINELEN/BEATLEN
// sequential single-outstanding beats, assembling fetched beats into FetchBuffer.
module cachelinebus #(
  parameter int PA_BITS = 34,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  parameter int LOGBWPL = 3
) (
  input logic            clk,
  input logic            reset,
  cachelinebus_if.slave  bus
);
  localparam int BEATS     = LINELEN / BEATLEN;
  localparam int OFFSETLEN = $clog2(LINELEN / 8);
  localparam int BYTEOFF   = $clog2(BEATLEN / 8);

  typedef enum logic [1:0] {IDLE, WRITE, RADR, RDATA} stateT;

  stateT                         state, nextState;
  logic [LOGBWPL-1:0]            beatCount;
  logic [BEATS-1:0][BEATLEN-1:0] fetchWords;
  logic                          lastBeat;
  logic                          beatInc, beatClr, captureBeat;
  logic                          memReq, memWrite, cacheBusAck, selBusBeat;
  logic [OFFSETLEN-1:0]          unusedAdrBits;

  // The request address is line aligned; its offset bits carry no information.
  assign unusedAdrBits = bus.CacheBusAdr[OFFSETLEN-1:0];

  assign lastBeat = (beatCount == LOGBWPL'(BEATS - 1));

  // State register: synchronous reset aborts any transfer without an ack.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and handshake decode; writeback wins when both request bits are set.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    nextState   = state;
    memReq      = 1'b0;
    memWrite    = 1'b0;
    cacheBusAck = 1'b0;
    selBusBeat  = 1'b0;
    beatInc     = 1'b0;
    beatClr     = 1'b0;
    captureBeat = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CacheBusRW[0] && !bus.FlushStage)             nextState = WRITE;
        else if (bus.CacheBusRW == 2'b10 && !bus.FlushStage)  nextState = RADR;
      end
      WRITE: begin
        selBusBeat = 1'b1;
        memReq     = 1'b1;
        memWrite   = 1'b1;
        if (bus.MemReady) begin
          if (lastBeat) begin
            cacheBusAck = 1'b1;
            beatClr     = 1'b1;
            nextState   = IDLE;
          end else begin
            beatInc = 1'b1;
          end
        end
      end
      RADR: begin
        selBusBeat = 1'b1;
        memReq     = 1'b1;
        if (bus.MemReady) nextState = RDATA;
      end
      RDATA: begin
        selBusBeat = 1'b1;
        if (bus.MemRValid) begin
          captureBeat = 1'b1;
          if (lastBeat) begin
            cacheBusAck = 1'b1;
            beatClr     = 1'b1;
            nextState   = IDLE;
          end else begin
            beatInc   = 1'b1;
            nextState = RADR;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Beat index: advances per accepted beat, returns to zero on every entry to IDLE.
  always_ff @(posedge clk) begin
    if (reset || beatClr) beatCount <= '0;
    else if (beatInc)     beatCount <= beatCount + 1'b1;
  end

  // Fetch buffer: only the slice of the beat being returned is written.
  // NOTE: this wide buffer is deliberately reset, since the cache may observe it right after reset.
  always_ff @(posedge clk) begin
    if (reset)            fetchWords <= '0;
    else if (captureBeat) fetchWords[beatCount] <= bus.MemRData;
  end

  assign bus.FetchBuffer  = fetchWords;
  assign bus.BeatCount    = beatCount;
  assign bus.SelBusBeat   = selBusBeat;
  assign bus.CacheBusAck  = cacheBusAck;
  assign bus.BusCommitted = (state != IDLE);
  assign bus.MemReq       = memReq;
  assign bus.MemWrite     = memWrite;
  assign bus.MemAdr       = {bus.CacheBusAdr[PA_BITS-1:OFFSETLEN], beatCount, {BYTEOFF{1'b0}}};
  assign bus.MemWData     = bus.ReadDataWord;
  assign bus.MemLast      = memReq && lastBeat;
endmodule
